// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out transmitter: start bit, N data bits LSB first, stop bit,
// each bit held CLKS_PER_BIT clocks; valid/ready load handshake, all outputs registered.
module piso_serial_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         load,
    output logic         ready,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(N) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [BW-1:0]  baud_r, baud_s;
    logic [CW-1:0]  bit_r, bit_s;
    logic [N-1:0]   shift_r, shift_s;
    logic           baud_end_s;
    logic           tx_s, ready_s, busy_s, done_s;

    assign baud_end_s = (baud_r == BAUD_LAST);

    // Next-state, counters, shifter, and the output values to be registered
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load) begin
                    shift_s = d;
                    baud_s  = {BW{1'b0}};
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_end_s) begin
                    baud_s  = {BW{1'b0}};
                    bit_s   = {CW{1'b0}};
                    state_s = DATA;
                end else begin
                    baud_s  = baud_r + BW'(1);
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_s  = {BW{1'b0}};
                    shift_s = shift_r >> 1;
                    bit_s   = bit_r + CW'(1);
                    if (bit_r == BIT_LAST) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    baud_s  = baud_r + BW'(1);
                end
            end
            STOP: begin
                if (baud_end_s) begin
                    baud_s  = {BW{1'b0}};
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    baud_s  = baud_r + BW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = {BW{1'b0}};
                bit_s   = {CW{1'b0}};
                shift_s = {N{1'b0}};
            end
        endcase

        // Outputs are derived from the upcoming state so the registers line up with it
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
        ready_s = (state_s == IDLE);
        busy_s  = ~ready_s;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            baud_r  <= {BW{1'b0}};
            bit_r   <= {CW{1'b0}};
            shift_r <= {N{1'b0}};
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx      <= tx_s;
            ready   <= ready_s;
            busy    <= busy_s;
            done    <= done_s;
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_piso_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, load, load1;
    logic [7:0] d, d1;
    logic       ready0, tx0, busy0, done0;
    logic       ready1, tx1, busy1, done1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    bit         cap0[$];
    bit         cap1[$];

    piso_serial_tx #(.N(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .d(d), .load(load),
        .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
    );

    piso_serial_tx #(.N(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .d(d1), .load(load1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Compare a captured busy-window of tx samples with the ideal framed waveform
    task automatic check_frame(input string name, input int sel, input logic [7:0] w, input int cpb);
        bit         got[$];
        bit         want[$];
        logic [9:0] fr;
        int         bad;
        if (sel == 0) got = cap0;
        else          got = cap1;
        fr = {1'b1, w, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < cpb; k++)
                want.push_back(fr[i]);
        chk({name, "_len"}, got.size(), want.size());
        bad = -1;
        if (got.size() == want.size())
            for (int i = 0; i < want.size(); i++)
                if (got[i] != want[i] && bad < 0) bad = i;
        chk({name, "_first_bad_idx"}, bad, -1);
    endtask

    // Monitor for the 4-clocks/bit instance
    always @(negedge clk) begin
        logic [7:0] w;
        if (rst) begin
            cap0.delete();
        end else begin
            if (busy0) cap0.push_back(tx0);
            if (done0) begin
                if (exp0.size() == 0) begin
                    chk("unexpected_frame0", 32'd1, 32'd0);
                end else begin
                    w = exp0.pop_front();
                    check_frame("frame0", 0, w, 4);
                end
                cap0.delete();
            end
        end
    end

    // Monitor for the 1-clock/bit instance
    always @(negedge clk) begin
        logic [7:0] w;
        if (rst) begin
            cap1.delete();
        end else begin
            if (busy1) cap1.push_back(tx1);
            if (done1) begin
                if (exp1.size() == 0) begin
                    chk("unexpected_frame1", 32'd1, 32'd0);
                end else begin
                    w = exp1.pop_front();
                    check_frame("frame1", 1, w, 1);
                end
                cap1.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!done0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(done0), 32'd1);
    endtask

    task automatic wait_done1(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!done1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(done1), 32'd1);
    endtask

    initial begin
        int dn;
        rst   = 1'b1;
        load  = 1'b1;
        d     = 8'hFF;
        load1 = 1'b0;
        d1    = 8'h00;

        // Reset held with load high: line stays idle
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_idle", 32'({tx0, ready0, busy0, done0}), 32'b1100);
        end
        rst  = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_idle", 32'({tx0, ready0, busy0, done0}), 32'b1100);
        end

        // Single frame 0xA5
        tick();
        exp0.push_back(8'hA5);
        d = 8'hA5; load = 1'b1;
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("start_latency", 32'({tx0, ready0, busy0}), 32'b001);
        wait_done0("single_done", 100);
        chk("done_ready", 32'(ready0), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done0), 32'd0);

        // Load while busy is ignored
        tick();
        exp0.push_back(8'h3C);
        d = 8'h3C; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (10) tick();
        d = 8'hFF; load = 1'b1;
        tick();
        load = 1'b0;
        wait_done0("ignore_done", 100);
        dn = 0;
        repeat (60) begin
            @(negedge clk);
            if (done0) dn++;
        end
        chk("ignore_no_second", dn, 0);
        chk("ignore_idle", 32'(busy0), 32'd0);

        // Back-to-back with load held high
        tick();
        exp0.push_back(8'h01);
        exp0.push_back(8'h80);
        d = 8'h01; load = 1'b1;
        tick();
        d = 8'h80;
        wait_done0("b2b_first", 100);
        chk("b2b_gap", 32'({tx0, ready0, busy0}), 32'b110);
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("b2b_second_start", 32'({tx0, ready0, busy0}), 32'b001);
        wait_done0("b2b_second", 100);

        // Reset during data bit 3 of 0x55
        tick();
        d = 8'h55; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (17) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'({tx0, ready0, busy0, done0}), 32'b1100);
        dn = 0;
        repeat (60) begin
            @(negedge clk);
            if (done0) dn++;
        end
        chk("abort_no_done", dn, 0);
        tick();
        exp0.push_back(8'h0F);
        d = 8'h0F; load = 1'b1;
        tick();
        load = 1'b0;
        wait_done0("after_abort_done", 100);

        // One clock per bit
        tick();
        exp1.push_back(8'hC3);
        d1 = 8'hC3; load1 = 1'b1;
        tick();
        load1 = 1'b0;
        @(negedge clk);
        chk("deg_start", 32'({tx1, busy1}), 32'b01);
        wait_done1("deg_done", 40);

        repeat (5) tick();
        chk("sb0_drained", exp0.size(), 0);
        chk("sb1_drained", exp1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in, serial-out transmitter. It accepts an N-bit word through a valid/ready load handshake and shifts it out on a single line as a framed serial stream: start bit, N data bits LSB first, stop bit. It is the transmit-side counterpart to the team's parallel storage registers. Its output feeds the lab serial link and the matching receiver.

Parameters:
N, 8, data word width in bits (N >= 1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx (CLKS_PER_BIT >= 1)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous active-high reset, sampled on the rising edge of clk
d  input  N  parallel word to transmit; sampled only when a load is accepted
load  input  1  request to send d; accepted when load && ready at a rising edge
ready  output  1  high when a new word can be accepted
tx  output  1  serial line; idles high
busy  output  1  high while a frame is in progress (START, DATA or STOP)
done  output  1  one-cycle pulse marking frame completion

Behaviour:
- Reset: synchronous and active-high; rst=1 at a rising edge forces state IDLE, tx=1, ready=1, busy=0, done=0, bit counter=0, baud counter=0, shift register=0. rst overrides load in the same cycle.
- Reset mid-frame: the frame is abandoned. tx returns to 1 in the cycle after the reset edge, with no partial stop bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, ready=1, busy=0. If load=1, capture d into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift_reg[0]. After CLKS_PER_BIT cycles, shift right by 1 and increment the bit counter. After bit N-1 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for exactly that first IDLE cycle.
- Latency: the start bit appears on tx in the cycle after load is accepted. A frame occupies exactly (N+2)*CLKS_PER_BIT cycles of busy=1.
- ready=0 and busy=1 from the cycle after acceptance through the last STOP cycle.
- ready=1 in the same cycle done=1.
- Loads while ready=0 are ignored and are not queued.
- Changes on d after acceptance have no effect on the frame in flight.
- Back-to-back transfers: load held high through the done cycle is accepted in that cycle, so the next start bit begins the following cycle. The minimum inter-frame idle is one cycle.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. CLKS_PER_BIT=1 must produce one bit per cycle with no stall cycles.
- The bit counter width is clog2(N)+1. It is cleared on entry to DATA and on reset.
- done is never asserted outside the single post-STOP cycle. It is never asserted after a reset-aborted frame.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with load=1 and d=8'hFF -> tx=1, ready=1, busy=0, done=0 throughout; no frame starts after rst drops unless load is still high.
- Single frame, N=8, CLKS_PER_BIT=4, d=8'hA5 with load pulsed 1 cycle:
  - tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles.
  - busy=1 for 40 cycles.
  - done=1 for exactly 1 cycle, right after the stop bit ends.
- Ignore while busy: send 8'h3C, then 10 cycles later pulse load with d=8'hFF -> the transmitted frame carries 0x3C only; no second frame follows.
- Back-to-back: hold load=1 continuously with d=8'h01, then d=8'h80 after the first accept -> two frames, exactly one tx=1 idle cycle (the done cycle) between the first stop bit and the second start bit.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h55 -> tx=1 and ready=1 the next cycle, done never pulses; a fresh load of 8'h0F then transmits correctly.
- Degenerate rate: N=8, CLKS_PER_BIT=1, d=8'hC3 -> tx=0,1,1,0,0,0,0,1,1,1 on 10 consecutive cycles, busy=1 for 10 cycles.
